// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM state encodings and counter sizing shared by serial_adder
package serial_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fa_bit_cell.sv
// fa_bit_cell: combinational one-bit full adder
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/done handshake; SERIAL_ADD_OVF_EN adds the ovf port
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_width(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d, s_sh_nxt, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d, fa_s, fa_co, accept, run, last;
  fa_bit_cell u_fa (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .ci(c_q),
    .s (fa_s),
    .co(fa_co)
  );
  assign accept   = (state_q == ST_IDLE) && start;
  assign run      = (state_q == ST_RUN);
  assign last     = run && (cnt_q == CW'(WIDTH - 1));
  // the new sum bit enters at the MSB so the word is aligned after WIDTH shifts
  assign s_sh_nxt = WIDTH'({fa_s, s_sh_q} >> 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? ST_RUN : last ? ST_DONE : run ? ST_RUN : ST_IDLE;
  end
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end
  always_comb begin
    a_sh_d = accept ? a : run ? (a_sh_q >> 1) : a_sh_q;
    b_sh_d = accept ? b : run ? (b_sh_q >> 1) : b_sh_q;
    c_d    = accept ? ci : run ? fa_co : c_q;
    cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    s_sh_d = run ? s_sh_nxt : s_sh_q;
    s_d    = last ? s_sh_nxt : s_q;
    co_d   = last ? fa_co : co_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      s_sh_q <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      co_q   <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      s_sh_q <= s_sh_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      co_q   <= co_d;
    end
  end
  assign s  = s_q;
  assign co = co_q;
`ifdef SERIAL_ADD_OVF_EN
  // operand sign bits are shifted out during RUN, so keep them aside
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
  always_comb begin
    a_msb_d = accept ? a[WIDTH-1] : a_msb_q;
    b_msb_d = accept ? b[WIDTH-1] : b_msb_q;
    ovf_d   = last ? ((a_msb_q == b_msb_q) && (fa_s != a_msb_q)) : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder against an arithmetic model
module tb_serial_adder;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ci_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0, s;
  logic busy, done, co;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
`endif
  typedef struct {
    int         cyc;
    logic [W:0] sum;
    logic       ovf;
  } exp_t;
  exp_t q[$];
  int cyc = 0, free_at = 0, vectors = 0, fails = 0;
  logic [W:0] res = '0;
  logic res_ovf = 1'b0;
  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a_i),
    .b    (b_i),
    .ci   (ci_i),
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int sx = int'(x) - (x[W-1] ? (1 << W) : 0);
    int sy = int'(y) - (y[W-1] ? (1 << W) : 0);
    int t = sx + sy + int'(c);
    return (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
  endfunction
  // reference: one accept per W+2 cycles, result appears W cycles after its accept edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      free_at = 0;
    end else begin
      cyc++;
      if (start && cyc >= free_at) begin
        exp_t e;
        e.cyc = cyc + W;
        e.sum = a_i + b_i + ci_i;
        e.ovf = signed_ovf(a_i, b_i, ci_i);
        q.push_back(e);
        free_at = cyc + W + 2;
      end
    end
  end
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res     = '0;
      res_ovf = 1'b0;
    end else begin
      logic exp_done;
      exp_done = (q.size() > 0) && (q[0].cyc == cyc);
      chk("done", done, exp_done);
      chk("busy", busy, cyc < free_at - 1);
      if (exp_done) begin
        exp_t e;
        e = q.pop_front();
        res     = e.sum;
        res_ovf = e.ovf;
      end
      chk("sum", {co, s}, res);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", ovf, res_ovf);
`endif
    end
  end
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    start = 1'b1;
    a_i = x;
    b_i = y;
    ci_i = c;
    @(negedge clk);
    start = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    ci_i = 1'($urandom);
    repeat (W + 1) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_s", s, 0);
    chk("idle_co", co, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("idle_ovf", ovf, 0);
`endif
    op(4'b0011, 4'b0101, 1'b0);
    chk("t2", {co, s}, 5'b01000);
`ifdef SERIAL_ADD_OVF_EN
    chk("t2_ovf", ovf, 1);
`endif
    op(4'b1111, 4'b0001, 1'b0);
    chk("t3a", {co, s}, 5'b10000);
`ifdef SERIAL_ADD_OVF_EN
    chk("t3a_ovf", ovf, 0);
`endif
    op(4'b0111, 4'b0001, 1'b1);
    chk("t3b", {co, s}, 5'b01001);
`ifdef SERIAL_ADD_OVF_EN
    chk("t3b_ovf", ovf, 1);
`endif
    @(negedge clk);
    start = 1'b1;
    repeat (40) begin
      a_i = W'($urandom);
      b_i = W'($urandom);
      ci_i = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    op(4'b1100, 4'b0001, 1'b0);
    chk("pre_rst", {co, s}, 5'b01101);
    @(negedge clk);
    start = 1'b1;
    a_i = 4'b0010;
    b_i = 4'b0011;
    ci_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    op(4'b0110, 4'b1001, 1'b1);
    chk("post_rst", {co, s}, 5'b10000);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      op(v[3:0], v[7:4], v[8]);
    end
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(W'($urandom), W'($urandom), 1'($urandom));
    end
    repeat (W + 4) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
